// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32 core: fetch handshake, instruction register,
// decode/execute/memory/writeback stepping, PC ownership and sticky error halt.

package core_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD     = 4'd0,
    ALU_OP_SUB     = 4'd1,
    ALU_OP_AND     = 4'd2,
    ALU_OP_OR      = 4'd3,
    ALU_OP_XOR     = 4'd4,
    ALU_OP_SLL     = 4'd5,
    ALU_OP_SRL     = 4'd6,
    ALU_OP_SRA     = 4'd7,
    ALU_OP_SLT     = 4'd8,
    ALU_OP_SLTU    = 4'd9,
    ALU_OP_INVALID = 4'd15
  } t_alu_operation;

  typedef enum logic [1:0] {
    BRANCH_NONE = 2'd0,
    BRANCH_NE   = 2'd1,
    BRANCH_JUMP = 2'd2
  } t_branch_condition;

endpackage

module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [31:0]       o_fetch_address,
  output logic              o_fetch_request,
  input  logic              i_fetch_ready,
  input  logic [31:0]       i_fetch_data,
  output logic [31:0]       o_instruction,
  input  t_alu_operation    i_alu_operation,
  input  t_branch_condition i_branch_condition,
  input  logic              i_destination_register_write_enable,
  input  logic              i_memory_write_enable,
  input  logic [31:0]       i_immediate,
  input  logic              i_alu_zero,
  output logic              o_register_write_enable,
  output logic              o_link_select,
  output logic [31:0]       o_return_address,
  output logic              o_memory_request,
  input  logic              i_memory_ready,
  output logic              o_retired,
  output logic              o_halted,
  output logic [1:0]        o_error
);

  localparam int              COUNT_W      = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(FETCH_TIMEOUT - 1);
  localparam logic [1:0]      ERR_NONE       = 2'd0;
  localparam logic [1:0]      ERR_ILLEGAL    = 2'd1;
  localparam logic [1:0]      ERR_MISALIGNED = 2'd2;
  localparam logic [1:0]      ERR_TIMEOUT    = 2'd3;
  localparam logic [6:0]      OPCODE_JAL     = 7'b110_1111;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } t_state;

  t_state               state_r;
  t_state               state_next_s;
  logic [31:0]          pc_r;
  logic [31:0]          ir_r;
  logic [COUNT_W-1:0]   count_r;
  logic [COUNT_W-1:0]   count_next_s;
  logic [1:0]           error_r;
  logic [1:0]           error_next_s;
  logic                 taken_s;
  logic [31:0]          target_s;
  logic                 taken_r;
  logic [31:0]          target_r;
  logic                 fetch_request_r;
  logic                 memory_request_r;
  logic                 register_write_enable_r;
  logic                 retired_r;
  logic                 halted_r;

  // Next-state, timeout counter and halt-cause selection
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    error_next_s = error_r;
    target_s     = pc_r + i_immediate;
    taken_s      = (i_branch_condition == BRANCH_JUMP) ||
                   ((i_branch_condition == BRANCH_NE) && !i_alu_zero);
    case (state_r)
      ST_FETCH: begin
        // Ready only counts while our request is visible; ready beats timeout
        if (fetch_request_r) begin
          if (i_fetch_ready) begin
            state_next_s = ST_DECODE;
            count_next_s = {COUNT_W{1'b0}};
          end else if (count_r == COUNT_LAST) begin
            state_next_s = ST_HALT;
            error_next_s = ERR_TIMEOUT;
          end else begin
            count_next_s = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if ((i_alu_operation == ALU_OP_INVALID) && (i_branch_condition != BRANCH_JUMP)) begin
          state_next_s = ST_HALT;
          error_next_s = ERR_ILLEGAL;
        end else begin
          state_next_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (taken_s && (target_s[1:0] != 2'b00)) begin
          state_next_s = ST_HALT;
          error_next_s = ERR_MISALIGNED;
        end else if (i_memory_write_enable) begin
          state_next_s = ST_MEMORY;
        end else begin
          state_next_s = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        if (memory_request_r && i_memory_ready) begin
          state_next_s = ST_WRITEBACK;
        end else begin
          state_next_s = ST_MEMORY;
        end
      end
      ST_WRITEBACK: state_next_s = ST_FETCH;
      ST_HALT:      state_next_s = ST_HALT;
      default:      state_next_s = ST_HALT;
    endcase
  end

  // Control state, error and strobe registers (strobes decode the state being entered)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r                 <= ST_FETCH;
      count_r                 <= {COUNT_W{1'b0}};
      error_r                 <= ERR_NONE;
      halted_r                <= 1'b0;
      fetch_request_r         <= 1'b0;
      memory_request_r        <= 1'b0;
      register_write_enable_r <= 1'b0;
      retired_r               <= 1'b0;
    end else begin
      state_r                 <= state_next_s;
      count_r                 <= count_next_s;
      error_r                 <= error_next_s;
      halted_r                <= halted_r | (state_next_s == ST_HALT);
      fetch_request_r         <= (state_next_s == ST_FETCH);
      memory_request_r        <= (state_next_s == ST_MEMORY);
      register_write_enable_r <= (state_next_s == ST_WRITEBACK) && i_destination_register_write_enable;
      retired_r               <= (state_next_s == ST_WRITEBACK);
    end
  end

  // Datapath registers: instruction, branch decision and program counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_r     <= RESET_VECTOR;
      ir_r     <= 32'h0000_0000;
      taken_r  <= 1'b0;
      target_r <= 32'h0000_0000;
    end else begin
      if ((state_r == ST_FETCH) && fetch_request_r && i_fetch_ready) begin
        ir_r <= i_fetch_data;
      end
      if (state_r == ST_EXECUTE) begin
        taken_r  <= taken_s;
        target_r <= target_s;
      end
      if (state_r == ST_WRITEBACK) begin
        pc_r <= taken_r ? target_r : (pc_r + 32'd4);
      end
    end
  end

  assign o_fetch_address         = pc_r;
  assign o_fetch_request         = fetch_request_r;
  assign o_instruction           = ir_r;
  assign o_register_write_enable = register_write_enable_r;
  assign o_link_select           = (ir_r[6:0] == OPCODE_JAL);
  assign o_return_address        = pc_r + 32'd4;
  assign o_memory_request        = memory_request_r;
  assign o_retired               = retired_r;
  assign o_halted                = halted_r;
  assign o_error                 = error_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: acts as instruction memory, decoder and data memory,
// pushes each instruction's expected outcome and compares when the core retires or halts.

module tb_core_sequencer;
  import core_sequencer_pkg::*;

  localparam logic [31:0] RESET_VECTOR  = 32'h0000_0000;
  localparam int          FETCH_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [31:0]       o_fetch_address;
  logic              o_fetch_request;
  logic              i_fetch_ready = 1'b0;
  logic [31:0]       i_fetch_data = 32'h0;
  logic [31:0]       o_instruction;
  t_alu_operation    i_alu_operation = ALU_OP_ADD;
  t_branch_condition i_branch_condition = BRANCH_NONE;
  logic              i_destination_register_write_enable = 1'b0;
  logic              i_memory_write_enable = 1'b0;
  logic [31:0]       i_immediate = 32'h0;
  logic              i_alu_zero = 1'b0;
  logic              o_register_write_enable;
  logic              o_link_select;
  logic [31:0]       o_return_address;
  logic              o_memory_request;
  logic              i_memory_ready = 1'b0;
  logic              o_retired;
  logic              o_halted;
  logic [1:0]        o_error;

  core_sequencer #(.RESET_VECTOR(RESET_VECTOR), .FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .o_fetch_address(o_fetch_address), .o_fetch_request(o_fetch_request),
    .i_fetch_ready(i_fetch_ready), .i_fetch_data(i_fetch_data),
    .o_instruction(o_instruction),
    .i_alu_operation(i_alu_operation), .i_branch_condition(i_branch_condition),
    .i_destination_register_write_enable(i_destination_register_write_enable),
    .i_memory_write_enable(i_memory_write_enable), .i_immediate(i_immediate),
    .i_alu_zero(i_alu_zero),
    .o_register_write_enable(o_register_write_enable), .o_link_select(o_link_select),
    .o_return_address(o_return_address), .o_memory_request(o_memory_request),
    .i_memory_ready(i_memory_ready), .o_retired(o_retired),
    .o_halted(o_halted), .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        halt;
    logic [1:0]  err;
    int          cycle;
    logic        we;
    logic        link;
    logic [31:0] ret;
    logic [31:0] pc_next;
    logic [31:0] instr;
    int          mcount;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_pc = RESET_VECTOR;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1; i_fetch_ready = 1'b0; i_memory_ready = 1'b0;
    @(negedge clk);
    check_value("rst_fetch_req", o_fetch_request, 0);
    check_value("rst_pc", o_fetch_address, RESET_VECTOR);
    check_value("rst_ret_addr", o_return_address, RESET_VECTOR + 32'd4);
    check_value("rst_ir", o_instruction, 0);
    check_value("rst_error", o_error, 0);
    check_value("rst_halted", o_halted, 0);
    @(negedge clk);
    check_value("rst_strobes", {o_fetch_request, o_memory_request, o_register_write_enable, o_retired}, 0);
    i_reset = 1'b0;
    model_pc = RESET_VECTOR;
  endtask

  // abort_at >= 0: assert reset on that memory-request cycle instead of completing
  task automatic run_instr(input logic [31:0] instr, input t_alu_operation alu,
                           input t_branch_condition br, input logic dwe, input logic mwe,
                           input logic [31:0] imm, input logic zero,
                           input int fwait, input int mwait, input int abort_at);
    exp_t        e;
    exp_t        got;
    logic        taken;
    logic [31:0] pc0;
    logic [31:0] tgt;
    logic [3:0]  strobes;
    int          c, fcnt, mcnt, wecnt;
    bit          started, done, aborted;
    pc0   = model_pc;
    taken = (br == BRANCH_JUMP) || ((br == BRANCH_NE) && !zero);
    tgt   = pc0 + imm;
    e.halt = 1'b0; e.err = 2'd0; e.we = dwe; e.link = (instr[6:0] == 7'h6F);
    e.ret = pc0 + 32'd4; e.pc_next = taken ? tgt : pc0 + 32'd4; e.instr = instr;
    e.mcount = mwe ? mwait + 1 : 0;
    e.cycle  = fwait + 3 + e.mcount;
    if (fwait >= FETCH_TIMEOUT) begin
      e.halt = 1'b1; e.err = 2'd3; e.cycle = FETCH_TIMEOUT;
    end else if ((alu == ALU_OP_INVALID) && (br != BRANCH_JUMP)) begin
      e.halt = 1'b1; e.err = 2'd1; e.cycle = fwait + 2;
    end else if (taken && (tgt[1:0] != 2'b00)) begin
      e.halt = 1'b1; e.err = 2'd2; e.cycle = fwait + 3;
    end
    if (abort_at < 0) sb_q.push_back(e);

    i_fetch_data = instr; i_alu_operation = alu; i_branch_condition = br;
    i_destination_register_write_enable = dwe; i_memory_write_enable = mwe;
    i_immediate = imm; i_alu_zero = zero;
    c = 0; fcnt = 0; mcnt = 0; wecnt = 0; started = 0; done = 0; aborted = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!started && o_fetch_request) begin
        started = 1;
        check_value("req_start", k, 0);
      end
      if (started) begin
        if (o_fetch_request) begin
          check_value("fetch_addr", o_fetch_address, pc0);
          i_fetch_ready = (fcnt == fwait);
          fcnt++;
        end else begin
          i_fetch_ready = 1'b0;
        end
        if (o_memory_request) begin
          mcnt++;
          if (abort_at >= 0 && mcnt == abort_at) begin
            i_reset = 1'b1; i_memory_ready = 1'b0; done = 1; aborted = 1;
          end else begin
            i_memory_ready = (mcnt == mwait + 1);
          end
        end else begin
          i_memory_ready = 1'b0;
        end
        if (o_register_write_enable) begin
          wecnt++;
          check_value("wb_link", o_link_select, e.link);
          check_value("wb_ret_addr", o_return_address, e.ret);
        end
        if (!done && (o_retired || o_halted)) begin
          done = 1;
          if (sb_q.size() == 0) begin
            check_value("sb_underflow", 1, 0);
          end else begin
            got = sb_q.pop_front();
            check_value("outcome_halt", o_halted, got.halt);
            check_value("outcome_cycle", c, got.cycle);
            check_value("outcome_error", o_error, got.err);
            if (!got.halt) begin
              check_value("retire_ir", o_instruction, got.instr);
              check_value("retire_we_count", wecnt, got.we);
              check_value("retire_mreq_count", mcnt, got.mcount);
              model_pc = got.pc_next;
            end else begin
              if (got.err == 2'd3) check_value("timeout_req_cycles", fcnt, FETCH_TIMEOUT);
              strobes = 4'd0;
              for (int h = 0; h < 4; h++) begin
                @(negedge clk);
                strobes = strobes | {o_fetch_request, o_memory_request, o_register_write_enable, o_retired};
              end
              check_value("halt_strobes", strobes, 0);
              check_value("halt_pc_frozen", o_fetch_address, pc0);
              check_value("halt_sticky", o_halted, 1);
            end
          end
        end
        c++;
      end
    end
    if (!done) check_value("instr_timeout", 0, 1);
    if (aborted) begin
      @(negedge clk);
      check_value("abort_mreq_drop", o_memory_request, 0);
      check_value("abort_no_side_effect", {o_retired, o_register_write_enable}, 0);
      check_value("abort_pc", o_fetch_address, RESET_VECTOR);
      i_reset = 1'b0;
      model_pc = RESET_VECTOR;
    end
  endtask

  initial begin
    do_reset();
    // addi x1,x0,5
    run_instr(32'h0050_0093, ALU_OP_ADD, BRANCH_NONE, 1'b1, 1'b0, 32'd5, 1'b1, 0, 0, -1);
    // sw x1,0(x2) with store ready delayed 3 cycles
    run_instr(32'h0011_2023, ALU_OP_ADD, BRANCH_NONE, 1'b0, 1'b1, 32'd0, 1'b0, 0, 3, -1);
    // jal x1,+24 : 0x08 -> 0x20
    run_instr(32'h0180_00EF, ALU_OP_ADD, BRANCH_JUMP, 1'b1, 1'b0, 32'd24, 1'b0, 0, 0, -1);
    // bne -8 taken : 0x20 -> 0x18
    run_instr(32'hFE20_9CE3, ALU_OP_SUB, BRANCH_NE, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b0, 0, 0, -1);
    // jal x0,+8 : 0x18 -> 0x20
    run_instr(32'h0080_006F, ALU_OP_ADD, BRANCH_JUMP, 1'b0, 1'b0, 32'd8, 1'b0, 0, 0, -1);
    // bne -8 not taken : 0x20 -> 0x24
    run_instr(32'hFE20_9CE3, ALU_OP_SUB, BRANCH_NE, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b1, 0, 0, -1);
    // jal x0,+28 : 0x24 -> 0x40
    run_instr(32'h01C0_006F, ALU_OP_ADD, BRANCH_JUMP, 1'b0, 1'b0, 32'd28, 1'b0, 0, 0, -1);
    // jal x1,+12 at 0x40 : link 0x44, next 0x4C
    run_instr(32'h00C0_00EF, ALU_OP_ADD, BRANCH_JUMP, 1'b1, 1'b0, 32'd12, 1'b0, 0, 0, -1);
    // fetch with two wait cycles, then ready on the final allowed cycle
    run_instr(32'h0050_0093, ALU_OP_ADD, BRANCH_NONE, 1'b1, 1'b0, 32'd5, 1'b1, 2, 0, -1);
    run_instr(32'h0050_0093, ALU_OP_ADD, BRANCH_NONE, 1'b1, 1'b0, 32'd5, 1'b1, FETCH_TIMEOUT - 1, 0, -1);
    // jal with +6 : misaligned target
    run_instr(32'h0060_006F, ALU_OP_ADD, BRANCH_JUMP, 1'b1, 1'b0, 32'd6, 1'b0, 0, 0, -1);
    do_reset();
    // illegal instruction
    run_instr(32'hFFFF_FFFF, ALU_OP_INVALID, BRANCH_NONE, 1'b0, 1'b0, 32'd0, 1'b0, 0, 0, -1);
    do_reset();
    run_instr(32'h0050_0093, ALU_OP_ADD, BRANCH_NONE, 1'b1, 1'b0, 32'd5, 1'b1, 0, 0, -1);
    do_reset();
    // fetch ready never arrives
    run_instr(32'h0050_0093, ALU_OP_ADD, BRANCH_NONE, 1'b1, 1'b0, 32'd5, 1'b1, 100, 0, -1);
    do_reset();
    // reset during a store wait
    run_instr(32'h0011_2023, ALU_OP_ADD, BRANCH_NONE, 1'b0, 1'b1, 32'd0, 1'b0, 0, 10, 2);
    run_instr(32'h0050_0093, ALU_OP_ADD, BRANCH_NONE, 1'b1, 1'b0, 32'd5, 1'b1, 0, 0, -1);
    check_value("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control state machine for the RV32 core. It fetches each instruction through a request/ready handshake and holds it in an instruction register that drives the decoder. It then steps the datapath through decode, execute, optional memory and writeback, and owns the program counter. It sits between instruction memory, the decoder, the ALU, the register file and data memory, and gates every side effect so that exactly one instruction retires at a time.

## Interface

- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- FETCH_TIMEOUT, 16, max cycles in FETCH without i_fetch_ready before error halt (≥1)
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset, synchronous, active-high
- o_fetch_address  out  32  current PC
- o_fetch_request  out  1  instruction fetch request
- i_fetch_ready  in  1  i_fetch_data valid this cycle
- i_fetch_data  in  32  fetched instruction word
- o_instruction  out  32  instruction register, feeds decoder
- i_alu_operation  in  t_alu_operation  from decoder
- i_branch_condition  in  t_branch_condition  from decoder (BRANCH_NONE/NE/JUMP)
- i_destination_register_write_enable  in  1  from decoder
- i_memory_write_enable  in  1  from decoder
- i_immediate  in  32  from decoder
- i_alu_zero  in  1  ALU result == 0
- o_register_write_enable  out  1  register-file write strobe
- o_link_select  out  1  1: write-back data is o_return_address, 0: ALU result
- o_return_address  out  32  PC + 4
- o_memory_request  out  1  data store request
- i_memory_ready  in  1  store accepted this cycle
- o_retired  out  1  one-cycle pulse per completed instruction
- o_halted  out  1  sticky, core stopped
- o_error  out  2  halt cause: 0 none, 1 illegal instruction, 2 misaligned target, 3 fetch timeout

## Operation

- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH: o_fetch_request=1; o_fetch_address stable until ready. On i_fetch_ready, latch i_fetch_data into o_instruction, clear the timeout counter, and go to DECODE. Otherwise increment the counter. When the counter reaches FETCH_TIMEOUT, go to HALT with o_error=3.
- DECODE: one cycle with no side effects. If i_alu_operation==ALU_OP_INVALID and i_branch_condition!=BRANCH_JUMP, go to HALT with o_error=1.
- EXECUTE: one cycle. Register taken = (JUMP) or (NE and !i_alu_zero). Register target = PC + i_immediate, modulo 2^32. If taken and target[1:0]!=0, go to HALT with o_error=2. Else if i_memory_write_enable, go to MEMORY; otherwise go to WRITEBACK.
- MEMORY: o_memory_request=1 until i_memory_ready is sampled high, then go to WRITEBACK. No timeout.
- WRITEBACK: o_register_write_enable = i_destination_register_write_enable for exactly this cycle. o_link_select=1 iff the instruction is JAL. PC ← taken ? target : PC+4 (wraps at 2^32). o_retired=1. Next state is FETCH.
- HALT: absorbing; only i_reset exits. All strobes are 0; PC and o_instruction are frozen.
- Strobes (o_fetch_request, o_memory_request, o_register_write_enable, o_retired) are decoded from state only and are never asserted outside their state.
- o_return_address = PC+4 at all times, combinational from PC.

## Timing

- Reset (synchronous, takes effect at the edge where i_reset=1):
  - state=FETCH, PC=RESET_VECTOR, o_instruction=0, counter=0, o_error=0, o_halted=0.
  - All strobes are 0 while i_reset is high. o_fetch_request rises the first cycle after i_reset falls.
- Reset mid-operation overrides every state. A pending fetch or store is abandoned and its request drops the next cycle. No retire and no register write occur.
- Latency, with ready in the first request cycle: 4 cycles per instruction, 5 per store. Each wait cycle on ready adds 1.
- Ready sampled while the matching request is low is ignored.
- Simultaneous i_fetch_ready with the counter reaching FETCH_TIMEOUT: ready wins and the fetch completes.
- Outputs are registered state decodes, except o_fetch_address, o_return_address and o_link_select, which are direct from registers/IR.

## Test plan

- Reset, then addi x1,x0,5 (32'h00500093) with immediate ready: request in cycle 0; write strobe and retire pulse in cycle 3; PC=4 at cycle 4.
- Store (sw) with i_memory_ready delayed 3 cycles: o_memory_request high for exactly 4 cycles; o_register_write_enable never asserted; retire at cycle 7 after fetch.
- bne with imm=-8 at PC=0x20: i_alu_zero=0 gives next PC=0x18; i_alu_zero=1 gives PC=0x24.
- jal x1,+12 at PC=0x40: write strobe with o_link_select=1 and o_return_address=0x44; next PC=0x4C. jal with imm=+6 gives HALT with o_error=2.
- Illegal opcode (32'hFFFFFFFF): HALT after DECODE with o_error=1; no strobes thereafter. i_reset then recovers to PC=RESET_VECTOR.
- i_fetch_ready held low: HALT with o_error=3 after exactly FETCH_TIMEOUT cycles. Ready arriving on the final cycle completes normally. Reset asserted during a store wait drops o_memory_request the next cycle.
